// File: rtl/id_decode_if.sv
// ============================================================================
//  Module      : id_decode_if
//  Description : Fetch/decode/writeback handshake and decoded-control bundle
//                for the RV32I instruction-decode stage.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface id_decode_if;
    logic        IF_kick_up;
    logic [31:0] inst_mem_read_data;
    logic        WB_kick_up;
    logic        ID_kick_up;
    logic        Controller_branch;
    logic        Controller_branch_kick_up;
    logic [31:0] imme;
    logic        imme_kick_up;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic        overrun;

    modport slave (
        input  IF_kick_up, inst_mem_read_data, WB_kick_up,
        output ID_kick_up, Controller_branch, Controller_branch_kick_up,
               imme, imme_kick_up, rs1, rs2, rd, alu_op, alu_src,
               mem_read, mem_write, reg_write, mem_to_reg, illegal, overrun
    );

    modport master (
        output IF_kick_up, inst_mem_read_data, WB_kick_up,
        input  ID_kick_up, Controller_branch, Controller_branch_kick_up,
               imme, imme_kick_up, rs1, rs2, rd, alu_op, alu_src,
               mem_read, mem_write, reg_write, mem_to_reg, illegal, overrun
    );
endinterface

`default_nettype wire

// File: rtl/id_decode.sv
// ============================================================================
//  Module      : id_decode
//  Description : RV32I decode stage: waits MEM_LATENCY edges for the fetched
//                word, decodes it and holds the result until writeback.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module id_decode #(
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    id_decode_if.slave    bus
);

    localparam logic [3:0] c_LATENCY   = 4'(MEM_LATENCY);

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;
    localparam logic [6:0] c_OPC_BR    = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_BNE   = 4'd10;
    localparam logic [3:0] c_ALU_BLT   = 4'd11;
    localparam logic [3:0] c_ALU_BGE   = 4'd12;
    localparam logic [3:0] c_ALU_BLTU  = 4'd13;
    localparam logic [3:0] c_ALU_BGEU  = 4'd14;
    localparam logic [3:0] c_ALU_PASSB = 4'd15;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_WAIT  = 2'd1,
        c_VALID = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_ir;
    logic        w_load;
    logic        w_capture;
    logic        w_decode;
    logic        w_overrun;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture happens on the edge the counter reaches zero; the decoded
    // outputs follow one edge later, on the edge that enters VALID.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_decode     = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.IF_kick_up) begin
                    w_load       = 1'b1;
                    w_state_next = c_WAIT;
                end
            end
            c_WAIT: begin
                w_overrun = bus.IF_kick_up;
                if (r_cnt == 4'd0) begin
                    w_decode     = 1'b1;
                    w_state_next = c_VALID;
                end else if (r_cnt == 4'd1) begin
                    w_capture = 1'b1;
                end
            end
            c_VALID: begin
                if (bus.WB_kick_up) begin
                    if (bus.IF_kick_up) begin
                        w_load       = 1'b1;
                        w_state_next = c_WAIT;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end else begin
                    w_overrun = bus.IF_kick_up;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_ir  <= 32'd0;
        end else begin
            if (w_load) begin
                r_cnt <= c_LATENCY;
            end else if (r_state == c_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_ir <= bus.inst_mem_read_data;
            end
        end
    end

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [3:0]  w_arith_op;
    logic [3:0]  w_branch_op;
    logic        w_branch_ok;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    // Halved branch offset: fetch doubles it when forming the target.
    assign w_imm_b  = {{20{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8]};
    assign w_imm_u  = {r_ir[31:12], 12'd0};

    always_comb begin
        w_arith_op = c_ALU_ADD;
        case (w_funct3)
            3'b000: w_arith_op = (w_opcode == c_OPC_OP && r_ir[30]) ? c_ALU_SUB : c_ALU_ADD;
            3'b001: w_arith_op = c_ALU_SLL;
            3'b010: w_arith_op = c_ALU_SLT;
            3'b011: w_arith_op = c_ALU_SLTU;
            3'b100: w_arith_op = c_ALU_XOR;
            3'b101: w_arith_op = r_ir[30] ? c_ALU_SRA : c_ALU_SRL;
            3'b110: w_arith_op = c_ALU_OR;
            default: w_arith_op = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_branch_op = c_ALU_SUB;
        w_branch_ok = 1'b1;
        case (w_funct3)
            3'b000: w_branch_op = c_ALU_SUB;
            3'b001: w_branch_op = c_ALU_BNE;
            3'b100: w_branch_op = c_ALU_BLT;
            3'b101: w_branch_op = c_ALU_BGE;
            3'b110: w_branch_op = c_ALU_BLTU;
            3'b111: w_branch_op = c_ALU_BGEU;
            default: w_branch_ok = 1'b0;
        endcase
    end

    logic [31:0] w_imme;
    logic [3:0]  w_alu_op;
    logic        w_alu_src;
    logic        w_branch;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_illegal;

    always_comb begin
        w_imme       = 32'd0;
        w_alu_op     = c_ALU_ADD;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_illegal    = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_alu_op    = w_arith_op;
                w_reg_write = 1'b1;
            end
            c_OPC_IMM: begin
                w_imme      = w_imm_i;
                w_alu_op    = w_arith_op;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_LOAD: begin
                w_imme       = w_imm_i;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            c_OPC_STORE: begin
                w_imme      = w_imm_s;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OPC_BR: begin
                if (w_branch_ok) begin
                    w_imme   = w_imm_b;
                    w_alu_op = w_branch_op;
                    w_branch = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_imme      = w_imm_u;
                w_alu_op    = c_ALU_PASSB;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    logic        r_kick;
    logic        r_overrun;
    logic [31:0] r_imme;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu_op;
    logic        r_alu_src;
    logic        r_branch;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic        r_illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kick       <= 1'b0;
            r_overrun    <= 1'b0;
            r_imme       <= 32'd0;
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
            r_alu_op     <= 4'd0;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_kick <= w_decode;
            if (w_overrun) begin
                r_overrun <= 1'b1;
            end
            if (w_decode) begin
                r_imme       <= w_imme;
                r_rs1        <= r_ir[19:15];
                r_rs2        <= r_ir[24:20];
                r_rd         <= r_ir[11:7];
                r_alu_op     <= w_alu_op;
                r_alu_src    <= w_alu_src;
                r_branch     <= w_branch;
                r_mem_read   <= w_mem_read;
                r_mem_write  <= w_mem_write;
                r_reg_write  <= w_reg_write;
                r_mem_to_reg <= w_mem_to_reg;
                r_illegal    <= w_illegal;
            end
        end
    end

    assign bus.ID_kick_up                = r_kick;
    assign bus.Controller_branch_kick_up = r_kick;
    assign bus.imme_kick_up              = r_kick;
    assign bus.Controller_branch         = r_branch;
    assign bus.imme                      = r_imme;
    assign bus.rs1                       = r_rs1;
    assign bus.rs2                       = r_rs2;
    assign bus.rd                        = r_rd;
    assign bus.alu_op                    = r_alu_op;
    assign bus.alu_src                   = r_alu_src;
    assign bus.mem_read                  = r_mem_read;
    assign bus.mem_write                 = r_mem_write;
    assign bus.reg_write                 = r_reg_write;
    assign bus.mem_to_reg                = r_mem_to_reg;
    assign bus.illegal                   = r_illegal;
    assign bus.overrun                   = r_overrun;

endmodule

`default_nettype wire

// File: doc/id_decode.md
Name: id_decode

Overview:
- Instruction-decode stage directly downstream of the fetch stage in the single-issue RV32I core.
- Captures the instruction word returned by instruction memory after the fetch handshake and decodes it into register indices, immediate and control signals.
- Issues one-cycle kick_up pulses to the fetch stage (branch flag, immediate) and to the execute stage.
- Holds its outputs stable until writeback retires the instruction.

Parameters:
- MEM_LATENCY, 1: clock edges between the edge that samples IF_kick_up and the edge at which inst_mem_read_data is valid. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- IF_kick_up  in  1  fetch stage has presented a new address to instruction memory.
- inst_mem_read_data  in  32  instruction word from instruction memory.
- WB_kick_up  in  1  current instruction retired; release decoded outputs.
- ID_kick_up  out  1  one-cycle pulse: decoded outputs valid.
- Controller_branch  out  1  instruction is a conditional branch.
- Controller_branch_kick_up  out  1  one-cycle pulse, coincident with ID_kick_up.
- imme  out  32  sign-extended immediate.
- imme_kick_up  out  1  one-cycle pulse, coincident with ID_kick_up.
- rs1, rs2, rd  out  5 each  register indices from inst[19:15], inst[24:20], inst[11:7].
- alu_op  out  4  ALU operation code.
- alu_src  out  1  1 = ALU operand B is imme.
- mem_read, mem_write, reg_write, mem_to_reg  out  1 each  datapath controls.
- illegal  out  1  unsupported opcode or funct3.
- overrun  out  1  sticky: IF_kick_up arrived while busy.

Behaviour:
- FSM states: IDLE, WAIT, VALID.
- IDLE: on IF_kick_up, load a 4-bit counter with MEM_LATENCY and go to WAIT.
- WAIT: decrement the counter each edge. When it reaches 0, register inst_mem_read_data into the instruction register and go to VALID.
- VALID: decoded outputs are registered from the instruction register on the entry edge and held constant while in VALID.
- Pulses: ID_kick_up, Controller_branch_kick_up and imme_kick_up are high for exactly the first VALID cycle.
- Latency: IF_kick_up sampled at edge E0 -> instruction captured at E0+MEM_LATENCY -> outputs and pulses registered at E0+MEM_LATENCY+1.
- VALID + WB_kick_up -> IDLE.
- VALID + WB_kick_up + IF_kick_up in the same cycle -> WAIT directly (accepted, not an overrun).
- WB_kick_up in IDLE or WAIT is ignored.
- IF_kick_up in WAIT, or in VALID without WB_kick_up, is ignored and sets overrun. overrun clears only on reset.
- Immediates:
  - I: sign-extend inst[31:20].
  - S: sign-extend {inst[31:25],inst[11:7]}.
  - B: sign-extend {inst[31],inst[7],inst[30:25],inst[11:8]}, i.e. byte offset/2, because fetch doubles it.
  - U: {inst[31:12],12'b0}.
  - J: sign-extend {inst[31],inst[19:12],inst[20],inst[30:21]} (offset/2).
  - R-type: imme = 0.
- alu_op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, BNE 10, BLT 11, BGE 12, BLTU 13, BGEU 14, PASSB 15.
  - Branch ops produce ALU result 0 when the branch is taken.
  - BEQ uses SUB.
- Opcode decode:
  - OP: alu_src=0, reg_write=1; funct7[5] selects SUB/SRA.
  - OP-IMM: alu_src=1, reg_write=1; funct7[5] selects SRAI.
  - LOAD: ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
  - STORE: ADD, alu_src=1, mem_write=1.
  - BRANCH: Controller_branch=1, alu_src=0.
  - LUI: PASSB, alu_src=1, reg_write=1.
- Any other opcode, or BRANCH with funct3 010/011: illegal=1 and every write/branch control is forced to 0.
- Reset (any time, including mid-WAIT): state IDLE, counter 0, instruction register 0, all outputs 0, overrun 0.

Test Plan:
- MEM_LATENCY=1, IF_kick_up at E0, data 0x00500093 (addi x1,x0,5) -> ID_kick_up at E2 only.
  - Expected: rd=1, rs1=0, imme=5, alu_op=0, alu_src=1, reg_write=1, Controller_branch=0.
- Data 0xFE208CE3 (beq x1,x2,-8) -> Controller_branch=1, imme=0xFFFFFFFC, rs1=1, rs2=2, alu_op=1, alu_src=0.
  - Controller_branch_kick_up and imme_kick_up pulse together for one cycle.
- Data 0x123452B7 (lui x5,0x12345) -> rd=5, imme=0x12345000, alu_op=15, reg_write=1.
- Data 0x00000000 -> illegal=1, reg_write=0, mem_write=0, Controller_branch=0. Second IF_kick_up while in VALID -> overrun=1 and stays 1.
- MEM_LATENCY=3 -> data changed at E1 and E2 is not captured; word at E3 is captured; ID_kick_up at E4.
  - Simultaneous WB_kick_up+IF_kick_up in VALID -> next ID_kick_up 4 cycles later, overrun=0.
- reset low during WAIT -> all outputs 0 immediately. After release, a new IF_kick_up decodes normally.
